// File: rtl/hilo_md_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer driving the HI/LO write path; stalls EX while busy.
// Optional MDU_DIVZERO_SHORTCUT_EN: divide-by-zero completes straight from IDLE.
module hilo_md_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        stall,
  output logic        done,
  output logic        hi_we,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_SIGN = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_signed;
  logic        r_qsign;
  logic        r_rsign;
  logic [4:0]  r_cnt;
  logic [31:0] r_a;      // |dividend| on entry, shifted into the quotient during DIV
  logic [31:0] r_b;
  logic [31:0] r_rem;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_accept;
  logic        w_zshort;
  logic        w_sop;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [32:0] w_shift;
  logic        w_ge;
  logic [31:0] w_rem_nxt;
  logic [63:0] w_uprod;
  logic [63:0] w_prod;

  assign w_accept = (r_state == S_IDLE) & start & ~flush;
  assign w_sop    = ~op[0];
  assign w_abs_a  = (w_sop & a[31]) ? (~a + 32'd1) : a;
  assign w_abs_b  = (w_sop & b[31]) ? (~b + 32'd1) : b;

`ifdef MDU_DIVZERO_SHORTCUT_EN
  assign w_zshort = op[1] & (b == 32'd0);
`else
  assign w_zshort = 1'b0;
`endif

  // 33-bit compare: a divisor at or above 2^31 would otherwise lose the shifted-out bit
  assign w_shift   = {r_rem, r_a[31]};
  assign w_ge      = w_shift >= {1'b0, r_b};
  assign w_rem_nxt = w_ge ? (w_shift[31:0] - r_b) : w_shift[31:0];

  assign w_uprod = {32'd0, r_a} * {32'd0, r_b};
  assign w_prod  = (r_signed & r_qsign) ? (~w_uprod + 64'd1) : w_uprod;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    stall  = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          stall = 1'b1;
          if (w_zshort) begin
            w_next = S_DONE;
          end else if (op[1]) begin
            w_next = S_DIV;
          end else begin
            w_next = S_MUL;
          end
        end
      end
      S_MUL: begin
        stall  = 1'b1;
        w_next = S_DONE;
      end
      S_DIV: begin
        stall = 1'b1;
        if (r_cnt == 5'd31) begin
          w_next = S_SIGN;
        end
      end
      S_SIGN: begin
        stall  = 1'b1;
        w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (flush) begin
      w_next = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_signed <= 1'b0;
      r_qsign  <= 1'b0;
      r_rsign  <= 1'b0;
      r_cnt    <= 5'd0;
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_rem    <= 32'd0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
    end else if (!flush) begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_signed <= w_sop;
            r_qsign  <= w_sop & (a[31] ^ b[31]);
            r_rsign  <= w_sop & a[31];
            r_a      <= w_abs_a;
            r_b      <= w_abs_b;
            r_cnt    <= 5'd0;
            r_rem    <= 32'd0;
            if (w_zshort) begin
              r_hi <= a;
              r_lo <= 32'hFFFF_FFFF;
            end
          end
        end
        S_MUL: begin
          r_hi <= w_prod[63:32];
          r_lo <= w_prod[31:0];
        end
        S_DIV: begin
          r_rem <= w_rem_nxt;
          r_a   <= {r_a[30:0], w_ge};
          r_cnt <= r_cnt + 5'd1;
        end
        S_SIGN: begin
          r_lo <= (r_signed & r_qsign) ? (~r_a + 32'd1) : r_a;
          r_hi <= (r_signed & r_rsign) ? (~r_rem + 32'd1) : r_rem;
        end
        default: ;
      endcase
    end
  end

  assign hi_we  = done;
  assign hi_out = r_hi;
  assign lo_out = r_lo;

endmodule

// File: tb/tb_hilo_md_ctrl.sv
// Scoreboard bench for hilo_md_ctrl: issuing side queues arithmetic results, monitor checks each done.
module tb_hilo_md_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        stall;
  logic        done;
  logic        hi_we;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  hilo_md_ctrl dut (
    .clk(clk), .resetn(resetn), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .stall(stall), .done(done), .hi_we(hi_we),
    .hi_out(hi_out), .lo_out(lo_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          acc;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [31:0] last_hi  = 32'd0;
  logic [31:0] last_lo  = 32'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on the architectural operands.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, qq, rr;
    logic [63:0] res;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    res = 64'd0;
    case (o)
      2'd0: res = sx * sy;
      2'd1: res = {32'd0, x} * {32'd0, y};
      2'd2: begin
        if (y == 32'd0) begin
`ifdef MDU_DIVZERO_SHORTCUT_EN
          res = {x, 32'hFFFF_FFFF};
`else
          res = {x, (x[31] ? 32'h0000_0001 : 32'hFFFF_FFFF)};
`endif
        end else begin
          qq = sx / sy;
          rr = sx % sy;
          res = {rr[31:0], qq[31:0]};
        end
      end
      default: begin
        if (y == 32'd0) res = {x, 32'hFFFF_FFFF};
        else            res = {x % y, x / y};
      end
    endcase
    return res;
  endfunction

  function automatic int latency(input logic [1:0] o, input logic [31:0] y);
    if (!o[1]) return 2;
`ifdef MDU_DIVZERO_SHORTCUT_EN
    if (y == 32'd0) return 1;
`endif
    return 34;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (resetn && (done || hi_we)) begin
      check("hi_we_eq_done", 64'(hi_we), 64'(done));
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no pending op", cyc);
      end else begin
        e = sb.pop_front();
        check("hi_out", 64'(hi_out), 64'(e.hi));
        check("lo_out", 64'(lo_out), 64'(e.lo));
        check("done_latency", 64'(cyc - e.acc), 64'(e.lat));
      end
    end
  end

  // Holds start until stall drops, returning in the DONE cycle with start still high.
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] r;
    int          st;
    int          lat;
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    r     = model(o, x, y);
    lat   = latency(o, y);
    sb.push_back('{r[63:32], r[31:0], cyc, lat});
    last_hi = r[63:32];
    last_lo = r[31:0];
    #1;
    st = 0;
    while (stall && st < 100) begin
      st++;
      @(negedge clk);
    end
    check("stall_cycles", 64'(st), 64'(lat));
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0]  o;
    logic [31:0] x;
    logic [31:0] y;

    resetn = 1'b0;
    start  = 1'b0;
    flush  = 1'b0;
    op     = 2'd0;
    a      = 32'd0;
    b      = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi_we", 64'(hi_we), 64'd0);
    check("rst_hi", 64'(hi_out), 64'd0);
    check("rst_lo", 64'(lo_out), 64'd0);
    resetn = 1'b1;
    idle(1);

    issue(2'd0, 32'hFFFF_FFFE, 32'd3);
    issue(2'd1, 32'hFFFF_FFFE, 32'd3);
    issue(2'd2, 32'hFFFF_FFF9, 32'd2);
    issue(2'd3, 32'd100, 32'd7);
    issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(2'd3, 32'h0000_1234, 32'd0);
    issue(2'd2, 32'hFFFF_1234, 32'd0);
    issue(2'd0, 32'h8000_0000, 32'h8000_0000);
    idle(3);

    // Flush mid-DIV with start still held: no completion, results retained.
    @(negedge clk);
    start = 1'b1; op = 2'd2; a = 32'd12345; b = 32'd17;
    repeat (6) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    #1;
    check("flush_div_stall", 64'(stall), 64'd0);
    @(negedge clk);
    #1;
    check("flush_start_stall", 64'(stall), 64'd0);
    check("flush_hi_kept", 64'(hi_out), 64'(last_hi));
    check("flush_lo_kept", 64'(lo_out), 64'(last_lo));
    idle(3);

    // start and flush together in IDLE must not be accepted.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 2'd0; a = 32'd9; b = 32'd9;
    #1;
    check("start_flush_stall", 64'(stall), 64'd0);
    @(negedge clk);
    #1;
    check("start_flush_not_taken", 64'(stall), 64'd0);
    idle(2);

    // Asynchronous reset partway through a DIV.
    @(negedge clk);
    start = 1'b1; op = 2'd3; a = 32'hDEAD_BEEF; b = 32'd3;
    repeat (11) @(negedge clk);
    start  = 1'b0;
    resetn = 1'b0;
    #1;
    check("midrst_stall", 64'(stall), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_hi", 64'(hi_out), 64'd0);
    check("midrst_lo", 64'(lo_out), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    issue(2'd0, 32'd5, 32'hFFFF_FFFA);
    idle(2);

    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0:       x = 32'h8000_0000;
        1:       x = 32'(-$urandom_range(1, 50));
        default: x = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       y = 32'd0;
        1:       y = 32'hFFFF_FFFF;
        2:       y = 32'h8000_0000;
        3:       y = 32'($urandom_range(1, 15));
        default: y = $urandom;
      endcase
      issue(o, x, y);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 2));
    end
    idle(5);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
